// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with a registered,
// mutually aligned decode of sync, data-enable, coordinates and start strobes.
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;  // exclusive
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;  // exclusive

  // Every boundary is compared as an unsigned CW-bit value.
  localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
  localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
  localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
  localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);
  localparam logic          HS_ON      = (HS_POL != 0);
  localparam logic          VS_ON      = (VS_POL != 0);

  // Totals (and therefore every sync boundary) must be representable in CW bits.
  if ((longint'(H_TOTAL) >= (longint'(1) << CW)) ||
      (longint'(V_TOTAL) >= (longint'(1) << CW))) begin : g_cw_too_small
    $error("video_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  // h_q/v_q hold the position that the next enabled edge will present.
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] pixel_x_q;
  logic [CW-1:0] pixel_y_q;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next counter position: h wraps at end of line, v steps only on that wrap.
  always_comb begin
    h_d = h_q + CW'(1);
    v_d = v_q;
    if (h_q == H_LAST_C) begin
      h_d = '0;
      if (v_q == V_LAST_C) v_d = '0;
      else                 v_d = v_q + CW'(1);
    end
  end

  // Decode of the current counter position into the output set.
  always_comb begin
    de_d          = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hsync_d       = ((h_q >= HS_START_C) && (h_q < HS_END_C)) ? HS_ON : ~HS_ON;
    vsync_d       = ((v_q >= VS_START_C) && (v_q < VS_END_C)) ? VS_ON : ~VS_ON;
    line_start_d  = (h_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0);
  end

  // Counters and registered outputs; stalled cycles hold state but kill strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (en) begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_x_q     <= h_q;
      pixel_y_q     <= v_q;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster (15 x 8) with
// active-high hsync and active-low vsync.
module tb_video_timing_gen;

  localparam int CW = 8;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;   // H_TOTAL 15, hsync x=10..12
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;   // V_TOTAL 8,  vsync y=5..6
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] pixel_x, pixel_y;

  video_timing_gen #(
    .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(0)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
  } out_t;

  out_t exp_q[$];
  out_t held;
  int   mh, mv;
  int   vectors = 0;
  int   miscompares = 0;
  int   fs_cnt, ls_cnt, de_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the outputs must show after the next edge for given inputs.
  function automatic out_t model_step(input logic r, input logic e);
    out_t o;
    if (r) begin
      o = '{hs:1'b0, vs:1'b1, de:1'b0, x:'0, y:'0, ls:1'b0, fs:1'b0};
      mh = 0;
      mv = 0;
    end else if (e) begin
      o.x  = CW'(mh);
      o.y  = CW'(mv);
      o.de = (mh < HA) && (mv < VA);
      o.hs = (mh >= 10 && mh <= 12);
      o.vs = !(mv >= 5 && mv <= 6);
      o.ls = (mh == 0);
      o.fs = (mh == 0) && (mv == 0);
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end else begin
      o    = held;
      o.ls = 1'b0;
      o.fs = 1'b0;
    end
    held = o;
    return o;
  endfunction

  task automatic step(input logic r, input logic e);
    out_t ex;
    @(negedge clk);
    rst = r;
    en  = e;
    exp_q.push_back(model_step(r, e));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      ex = exp_q.pop_front();
      check("hsync",       {31'd0, hsync},       {31'd0, ex.hs});
      check("vsync",       {31'd0, vsync},       {31'd0, ex.vs});
      check("de",          {31'd0, de},          {31'd0, ex.de});
      check("pixel_x",     {24'd0, pixel_x},     {24'd0, ex.x});
      check("pixel_y",     {24'd0, pixel_y},     {24'd0, ex.y});
      check("line_start",  {31'd0, line_start},  {31'd0, ex.ls});
      check("frame_start", {31'd0, frame_start}, {31'd0, ex.fs});
    end
    fs_cnt += int'(frame_start);
    ls_cnt += int'(line_start);
    de_cnt += int'(de);
  endtask

  initial begin
    mh = 0;
    mv = 0;
    held = '0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Two full frames with en held high
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'b1);
    check("t1_frame_starts", fs_cnt, 2);
    check("t1_line_starts",  ls_cnt, 2 * VT);
    check("t1_de_cycles",    de_cnt, 2 * HA * VA);

    // en toggling: one frame of enabled cycles spread over twice the time
    fs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, (i % 2) == 0);
    check("t3_frame_starts", fs_cnt, 1);
    check("t3_line_starts",  ls_cnt, VT);

    // Mid-frame reset held for 3 cycles, then restart at (0,0)
    for (int i = 0; i < 3 * HT + 6; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t4_restart_x",  {24'd0, pixel_x}, 32'd0);
    check("t4_restart_fs", {31'd0, frame_start}, 32'd1);

    // Random enable with periodic reset
    for (int i = 0; i < 1500; i++)
      step((i % 400) == 399, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
